// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if: requester and shared-unit handshakes of cordic_arbiter.
// slave = arbiter view, master = environment view (requesters + unit).
interface cordic_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int PORTS = 4
);
  logic [PORTS-1:0]         req_valid;
  logic [PORTS-1:0]         req_ready;
  logic [PORTS*2*WIDTH-1:0] req_data;
  logic [PORTS-1:0]         rsp_valid;
  logic [PORTS-1:0]         rsp_ready;
  logic [2*WIDTH-1:0]       rsp_data;
  logic                     u_s_valid;
  logic                     u_s_ready;
  logic [2*WIDTH-1:0]       u_s_data;
  logic                     u_m_valid;
  logic                     u_m_ready;
  logic [2*WIDTH-1:0]       u_m_data;

  modport slave (
    input  req_valid, req_data, rsp_ready,
    input  u_s_ready, u_m_valid, u_m_data,
    output req_ready, rsp_valid, rsp_data,
    output u_s_valid, u_s_data, u_m_ready
  );

  modport master (
    output req_valid, req_data, rsp_ready,
    output u_s_ready, u_m_valid, u_m_data,
    input  req_ready, rsp_valid, rsp_data,
    input  u_s_valid, u_s_data, u_m_ready
  );
endinterface

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one in-order cart-to-polar unit among PORTS requesters.
// Ports: clk, reset_n (async low), bus (cordic_arbiter_if.slave, same WIDTH/PORTS).
// Grant is round-robin; CORDIC_ARBITER_FIXED_PRIORITY_EN selects lowest-port-wins.
// A tag FIFO of OUTSTANDING entries routes each in-order result back to its issuer.
module cordic_arbiter #(
  parameter int WIDTH       = 32,
  parameter int PORTS       = 4,
  parameter int OUTSTANDING = 18
) (
  input  logic                clk,
  input  logic                reset_n,
  cordic_arbiter_if.slave     bus
);

  localparam int DW = 2 * WIDTH;
  localparam int PW = $clog2(PORTS);
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int AW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [AW-1:0] LAST = AW'(OUTSTANDING - 1);
  localparam logic [CW-1:0] FULL = CW'(OUTSTANDING);

  logic [CW-1:0] cnt_q;
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic          lock_q;
  logic [PW-1:0] lock_g_q;
  logic [PW-1:0] tags [OUTSTANDING];

  logic [PW-1:0] pick;
  logic [PW-1:0] gnt;
  logic [PW-1:0] head;
  logic          any;
  logic          empty;
  logic          full;
  logic          m_ready;
  logic          retire;
  logic          s_valid;
  logic          issue;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef CORDIC_ARBITER_FIXED_PRIORITY_EN
  always_comb begin
    pick = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) pick = PW'(i);
    end
  end
`else
  logic [PW-1:0] rr_q;
  logic          found;

  // Search upward from the port after the last issued one.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= PORTS; i++) begin
      if (!found && bus.req_valid[(int'(rr_q) + i) % PORTS]) begin
        pick  = PW'((int'(rr_q) + i) % PORTS);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q <= PW'(PORTS - 1);
    end else if (issue) begin
      rr_q <= gnt;
    end
  end
`endif

  // A stalled offer keeps its port even if a preferred port wakes up.
  assign gnt = (lock_q && bus.req_valid[lock_g_q]) ? lock_g_q : pick;

  assign any     = |bus.req_valid;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL);
  assign head    = tags[rd_q];
  assign m_ready = reset_n & ~empty & bus.rsp_ready[head];
  assign retire  = bus.u_m_valid & m_ready;
  // A retire frees a slot in the same cycle, so a full FIFO can still issue.
  assign s_valid = reset_n & any & (~full | retire);
  assign issue   = s_valid & bus.u_s_ready;

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (issue) bus.req_ready[gnt] = 1'b1;
    if (reset_n && !empty && bus.u_m_valid) bus.rsp_valid[head] = 1'b1;
  end

  assign bus.u_s_valid = s_valid;
  assign bus.u_s_data  = bus.req_data[int'(gnt) * DW +: DW];
  assign bus.u_m_ready = m_ready;
  assign bus.rsp_data  = bus.u_m_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      lock_q   <= 1'b0;
      lock_g_q <= '0;
    end else begin
      if (issue && !retire) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (retire && !issue) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (issue)  wr_q <= bump(wr_q);
      if (retire) rd_q <= bump(rd_q);
      lock_q   <= s_valid & ~bus.u_s_ready;
      lock_g_q <= gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tags[wr_q] <= gnt;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (!(reset_n && bus.u_m_valid && empty))
      else $error("cordic_arbiter: unit result with no tag outstanding");
  end
`endif

endmodule
